// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP, one access per three cycles.
// Optional build macro DATA_MEM_ARB_RR_EN selects round-robin tie breaking;
// without it, port 0 wins every tie.
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitrate and latch the winner
//   ACCESS | memory strobed with the latched request, read data captured
//   RESP   | one-cycle ack to the winner with rd_data/err
module data_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rd_data,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        id_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;
  logic        last_grant_q;
  logic        grant_id;
  logic        any_req;
  logic        in_range;

  assign any_req  = req0 | req1;
  assign in_range = (addr_q[31:10] == 22'd0);

  // Pick the winning port; only meaningful while any_req is high.
  always_comb begin
    grant_id = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
    if (req0 && req1) grant_id = ~last_grant_q;
    else              grant_id = req1;
`else
    grant_id = ~req0;
`endif
  end

`ifndef DATA_MEM_ARB_RR_EN
  // last_grant is tracked in both builds but only steers round-robin.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; strobes and acks are gated by reset so an abort never writes or acks.
  always_comb begin
    mem_en    = (state_q == ACCESS) && in_range && !reset;
    mem_we    = (state_q == ACCESS) && in_range && we_q && !reset;
    ack0      = (state_q == RESP) && !id_q && !reset;
    ack1      = (state_q == RESP) &&  id_q && !reset;
    err       = (state_q == RESP) && !in_range && !reset;
    rd_data   = rd_data_q;
    mem_addr  = addr_q[9:0];
    mem_wdata = wdata_q;
  end

  // Request latch, grant history and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rd_data_q    <= 32'd0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            we_q         <= grant_id ? we1    : we0;
            addr_q       <= grant_id ? addr1  : addr0;
            wdata_q      <= grant_id ? wdata1 : wdata0;
          end
        end
        // Memory read is combinational, so this is the pre-write value on a write.
        ACCESS:  rd_data_q <= in_range ? mem_rdata : 32'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter against
// a word-array reference memory and a simple grant-history model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, mem_en, mem_we;
  logic [31:0] rd_data, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  int errors = 0;
  int checks = 0;
  int last_served = 1;

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];
  logic        init_mem;
  logic        wr_en_s;
  logic [9:0]  wr_a_s;
  logic [31:0] wr_d_s;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rd_data(rd_data), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the arbiter: combinational read, write on the rising edge.
  assign mem_rdata = tb_mem[mem_addr];

  initial wr_en_s = 1'b0;
  always @(negedge clk) begin
    wr_en_s = mem_en && mem_we;
    wr_a_s  = mem_addr;
    wr_d_s  = mem_wdata;
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (wr_en_s) begin
      tb_mem[wr_a_s] <= wr_d_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge while the arbiter is idle.
  task automatic do_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        oor;
    logic [9:0]  idx;
    logic [31:0] exp_rd;
    oor    = (a[31:10] != 22'd0);
    idx    = a[9:0];
    exp_rd = oor ? 32'd0 : ref_mem[idx];
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    @(posedge clk); @(negedge clk);
    chk1("access_mem_en", mem_en, !oor);
    chk1("access_mem_we", mem_we, !oor && w);
    if (!oor) begin
      chk("access_mem_addr", {22'd0, mem_addr}, {22'd0, idx});
      if (w) chk("access_mem_wdata", mem_wdata, d);
    end
    chk1("access_no_ack", ack0 | ack1, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("resp_ack0", ack0, p == 0);
    chk1("resp_ack1", ack1, p == 1);
    chk1("resp_err", err, oor);
    chk("resp_rd_data", rd_data, exp_rd);
    chk1("resp_mem_en", mem_en, 1'b0);
    if (!oor && w) ref_mem[idx] = d;
    last_served = p;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk1("idle_no_ack", ack0 | ack1, 1'b0);
  endtask

  initial begin
    int w;
    logic [31:0] a;
    reset = 1'b1; init_mem = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
    @(posedge clk); @(posedge clk); @(negedge clk);
    init_mem = 1'b0;
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk1("idle_mem_en", mem_en, 1'b0);

    // Write then read back the same word.
    do_access(0, 1'b1, 32'd5, 32'hDEADBEEF);
    do_access(0, 1'b0, 32'd5, 32'd0);

    // Out-of-range write on port 1.
    do_access(1, 1'b1, 32'h400, 32'h1234_5678);

    // Both ports reading, requests held throughout.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd9;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (c % 3 == 2) begin
`ifdef DATA_MEM_ARB_RR_EN
        w = 1 - last_served;
`else
        w = 0;
`endif
        last_served = w;
        chk1("tie_ack0", ack0, w == 0);
        chk1("tie_ack1", ack1, w == 1);
        chk("tie_rd_data", rd_data, ref_mem[(w == 1) ? 9 : 5]);
        chk1("tie_err", err, 1'b0);
      end else begin
        chk1("tie_quiet", ack0 | ack1, 1'b0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset during ACCESS aborts a write.
    do_access(0, 1'b1, 32'd7, 32'h1111_2222);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'hBADB_AD00;
    @(posedge clk);
    #1 reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk1("abort_mem_we", mem_we, 1'b0);
    chk1("abort_mem_en", mem_en, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    last_served = 1;
    @(negedge clk);
    chk1("abort_no_ack", ack0 | ack1, 1'b0);
    chk1("abort_idle_en", mem_en, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("abort_still_idle", ack0 | ack1 | mem_en, 1'b0);
    do_access(0, 1'b0, 32'd7, 32'd0);

    // Random single-port traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:10] == 22'd0) a[31] = 1'b1;
      end else begin
        a = 32'($urandom_range(0, 15));
      end
      do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
- REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-003 The block SHALL have ports req0/req1, input, 1 bit each: access request from port 0 (CPU load/store) and port 1 (loader/debug).
- REQ-004 The block SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
- REQ-005 The block SHALL have ports addr0/addr1, input, 32 bits each: word index.
- REQ-006 The block SHALL have ports wdata0/wdata1, input, 32 bits each: write data.
- REQ-007 The block SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse for the matching port.
- REQ-008 The block SHALL have port rd_data, output, 32 bits: read result, valid only while ack0 or ack1 is high.
- REQ-009 The block SHALL have port err, output, 1 bit: out-of-range flag, valid only while ack0 or ack1 is high.
- REQ-010 The block SHALL have ports mem_en and mem_we, output, 1 bit each: memory access strobe and write strobe.
- REQ-011 The block SHALL have ports mem_addr, output, 10 bits, and mem_wdata, output, 32 bits: memory address and write data.
- REQ-012 The block SHALL have port mem_rdata, input, 32 bits: combinational memory read data.

Function
- REQ-013 The block SHALL implement an FSM with states IDLE, ACCESS and RESP, and only these states.
- REQ-014 In IDLE with any req high, the block SHALL arbitrate, latch the winner's id, we, addr and wdata, and go to ACCESS; with no req it SHALL stay in IDLE.
- REQ-015 In ACCESS, the block SHALL drive mem_en=1, drive mem_we equal to the latched we, drive mem_addr from latched addr[9:0] and mem_wdata from the latched wdata, capture mem_rdata into rd_data, and go to RESP.
- REQ-016 In RESP, the block SHALL pulse the winner's ack for exactly one cycle and return to IDLE.
- REQ-017 Fixed latency SHALL be: req sampled at edge N gives ack high in cycle N+2; the maximum throughput is one access per 3 cycles.
- REQ-018 A requester SHALL hold req, we, addr and wdata stable until its ack; req is sampled only in IDLE.
- REQ-019 The cycle after an ack, the block SHALL treat a still-high req as a new request.
- REQ-020 For an out-of-range access (addr[31:10] != 0), the block SHALL hold mem_en=0 and mem_we=0 in ACCESS, and in RESP SHALL return rd_data=0 and err=1 with the ack; otherwise err=0.
- REQ-021 For a write, the block SHALL return rd_data equal to the pre-write memory contents.
- REQ-022 mem_en and mem_we SHALL be combinational decodes of state AND NOT reset.
- REQ-023 mem_en and mem_we SHALL be 0 in IDLE and RESP.
- REQ-024 With both req high in IDLE, the block SHALL pick exactly one winner per the REQ-032/REQ-033 policy; the loser SHALL be served in a later IDLE if its req is still held.
- REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
- REQ-026 On reset, the block SHALL set state to IDLE.
- REQ-027 On reset, the block SHALL set ack0, ack1, err, mem_en and mem_we to 0.
- REQ-028 On reset, the block SHALL set rd_data, mem_addr, mem_wdata and all latched fields to 0.
- REQ-029 On reset, the block SHALL set last_grant to 1.
- REQ-030 Reset asserted in ACCESS SHALL suppress mem_we in that cycle, so no memory write occurs, and SHALL abort the transaction with no ack.
- REQ-031 Reset asserted in RESP SHALL suppress the ack.

Configuration
- REQ-032 With DATA_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the port not equal to last_grant wins; last_grant updates on every grant.
- REQ-033 With DATA_MEM_ARB_RR_EN undefined, arbitration SHALL be fixed priority with port 0 winning every tie; last_grant SHALL be present but SHALL NOT affect arbitration.

Verification
- REQ-034 The bench SHALL cover: after reset, req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF -> mem_en=mem_we=1, mem_addr=5 at cycle N+1; ack0 at N+2; err=0.
- REQ-035 The bench SHALL cover: after REQ-034, req0=1, we0=0, addr0=5 -> ack0 at N+2 with rd_data=0xDEADBEEF.
- REQ-036 The bench SHALL cover: req0=req1=1 held continuously, both reads -> with RR the acks alternate ack0, ack1, ack0, ... every 3 cycles; with fixed priority only ack0 pulses.
- REQ-037 The bench SHALL cover: req1=1, we1=1, addr1=0x400 -> mem_we stays 0 throughout; ack1 with err=1 and rd_data=0.
- REQ-038 The bench SHALL cover: req0 write to addr0=7, reset pulsed in the ACCESS cycle -> no mem_we pulse, no ack0, state IDLE next cycle, and a subsequent read of addr 7 returns its old value.
